// File: rtl/binary_search_datapath_if.sv
// Request/result bundle for the binary-search engine.
//   start : level request, sampled while the engine is idle
//   A     : 8-bit search key, held stable from start until done
//   found : key matched (valid while done is high)
//   L     : low-bound index; matching index on a hit
//   done  : search finished, result held
interface binary_search_datapath_if;
    logic       start;
    logic [7:0] A;
    logic       found;
    logic [4:0] L;
    logic       done;

    // Requester side (system or bench).
    modport master (
        output start,
        output A,
        input  found,
        input  L,
        input  done
    );

    // Engine side.
    modport slave (
        input  start,
        input  A,
        output found,
        output L,
        output done
    );
endinterface

// File: rtl/binary_search_datapath.sv
// Sequential binary search over a fixed ascending table mem[i] = 2*i + 1,
// i = 0..31 (odd values 1..63). One probe per clock, at most 6 probes.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : slave modport of binary_search_datapath_if (start, A in;
//           found, L, done out -- all registered)
module binary_search_datapath (
    input  logic                          clk,
    input  logic                          reset,
    binary_search_datapath_if.slave       bus
);

    localparam int unsigned DEPTH  = 32;
    localparam int unsigned IDX_W  = 5;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned SUM_W  = IDX_W + 1;

    localparam logic [IDX_W-1:0] IDX_MIN = IDX_W'(0);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DEPTH - 1);
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] lo;
    logic [IDX_W-1:0] hi;
    logic             found_q;
    logic             done_q;

    logic [SUM_W-1:0]  mid_sum_c;
    logic [IDX_W-1:0]  mid_c;
    logic [DATA_W-1:0] probe_c;
    logic              key_eq_c;
    logic              key_gt_c;
    logic              bounds_met_c;
    logic              mid_at_lo_c;

    // Midpoint: sum kept at 6 bits so lo + hi cannot overflow before halving.
    always_comb begin
        mid_sum_c = SUM_W'(lo) + SUM_W'(hi);
        mid_c     = IDX_W'(mid_sum_c >> 1);
    end

    // Table ROM: 2*mid + 1 is the index shifted left with a forced LSB of 1.
    always_comb begin
        probe_c = {(DATA_W - IDX_W - 1)'(0), mid_c, 1'b1};
    end

    // Probe comparisons against the key.
    always_comb begin
        key_eq_c     = (probe_c == bus.A);
        key_gt_c     = (probe_c < bus.A);
        bounds_met_c = (lo == hi);
        mid_at_lo_c  = (mid_c == lo);
    end

    // Controller and datapath registers; every output is a register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            lo      <= IDX_MIN;
            hi      <= IDX_MAX;
            found_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    found_q <= 1'b0;
                    done_q  <= 1'b0;
                    if (bus.start) begin
                        lo    <= IDX_MIN;
                        hi    <= IDX_MAX;
                        state <= SEARCH;
                    end
                end

                SEARCH: begin
                    if (key_eq_c) begin
                        // Hit: park the matched index in lo so L reports it.
                        lo      <= mid_c;
                        found_q <= 1'b1;
                        done_q  <= 1'b1;
                        state   <= DONE;
                    end else if (bounds_met_c) begin
                        found_q <= 1'b0;
                        done_q  <= 1'b1;
                        state   <= DONE;
                    end else if (key_gt_c) begin
                        // mid < hi here, so mid + 1 stays in range.
                        lo <= mid_c + IDX_ONE;
                    end else if (mid_at_lo_c) begin
                        // Key is below the lowest remaining entry; mid - 1 would wrap.
                        found_q <= 1'b0;
                        done_q  <= 1'b1;
                        state   <= DONE;
                    end else begin
                        hi <= mid_c - IDX_ONE;
                    end
                end

                DONE: begin
                    // Hold the result while start stays high: one search per request.
                    if (!bus.start) begin
                        found_q <= 1'b0;
                        done_q  <= 1'b0;
                        state   <= IDLE;
                    end
                end

                default: begin
                    found_q <= 1'b0;
                    done_q  <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.found = found_q;
    assign bus.done  = done_q;
    assign bus.L     = lo;

endmodule

// File: tb/tb_binary_search_datapath.sv
// Scoreboard bench for binary_search_datapath: the stimulus process pushes the
// expected result of each search; a monitor pops and checks on each rising done.
module tb_binary_search_datapath;

    typedef struct {
        logic [7:0] key;
        bit         hit;
        logic [4:0] idx;
        int         probes;
        int         start_cyc;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc;
    int   checks;
    int   failures;
    exp_t sb_q[$];

    binary_search_datapath_if bus ();

    binary_search_datapath dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: the table holds odd numbers 1..63 at index (v-1)/2.
    // Probe count follows the search rules over the plain value array.
    function automatic exp_t make_exp(input logic [7:0] key);
        exp_t e;
        int   table_v[32];
        int   lo, hi, mid, n, k;
        k = int'(key);
        for (int i = 0; i < 32; i++) table_v[i] = 2 * i + 1;
        e.key       = key;
        e.hit       = (k % 2 == 1) && (k <= 63);
        e.idx       = e.hit ? 5'((k - 1) / 2) : 5'd0;
        e.start_cyc = 0;
        lo = 0; hi = 31; n = 0;
        forever begin
            mid = (lo + hi) / 2;
            n++;
            if (table_v[mid] == k) break;
            if (lo == hi) break;
            if (table_v[mid] < k) lo = mid + 1;
            else if (mid == lo) break;
            else hi = mid - 1;
        end
        e.probes = n;
        return e;
    endfunction

    // Monitor: checks each completed search against the oldest expectation.
    logic done_prev;
    initial done_prev = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (bus.done === 1'b1 && done_prev !== 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = sb_q.pop_front();
                chk($sformatf("found key=%0d", e.key), int'(bus.found), int'(e.hit));
                if (e.hit) chk($sformatf("L key=%0d", e.key), int'(bus.L), int'(e.idx));
                chk($sformatf("latency key=%0d", e.key), cyc - e.start_cyc, e.probes);
            end
        end
        done_prev = bus.done;
    end

    // One full request: raise start, wait for done, hold, then drop start.
    task automatic run_search(input logic [7:0] key, input int hold);
        exp_t e;
        bit   ok;
        @(negedge clk);
        bus.A     = key;
        bus.start = 1'b1;
        e = make_exp(key);
        e.start_cyc = cyc + 1;
        sb_q.push_back(e);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            chk($sformatf("done_timeout key=%0d", key), 0, 1);
            void'(sb_q.pop_back());
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("held_done", int'(bus.done), 1);
            chk("held_found", int'(bus.found), int'(e.hit));
            if (e.hit) chk("held_L", int'(bus.L), int'(e.idx));
        end
        bus.start = 1'b0;
        @(negedge clk);
        chk("idle_done", int'(bus.done), 0);
        chk("idle_found", int'(bus.found), 0);
    endtask

    initial begin
        logic [7:0] key;
        checks    = 0;
        failures  = 0;
        reset     = 1'b0;
        bus.start = 1'b0;
        bus.A     = 8'h00;

        #4 reset = 1'b1;
        #4;
        chk("reset_done", int'(bus.done), 0);
        chk("reset_found", int'(bus.found), 0);
        chk("reset_L", int'(bus.L), 0);
        #4 reset = 1'b0;
        @(negedge clk);
        chk("post_reset_done", int'(bus.done), 0);

        // Directed cases, first one starts at 30 ns.
        run_search(8'h0F, 3);
        run_search(8'd1, 1);
        run_search(8'd63, 1);
        run_search(8'd16, 1);
        run_search(8'd0, 1);
        run_search(8'd255, 1);

        // Reset in the middle of a 5-probe search.
        @(negedge clk);
        bus.A     = 8'd5;
        bus.start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        chk("abort_done", int'(bus.done), 0);
        chk("abort_found", int'(bus.found), 0);
        chk("abort_L", int'(bus.L), 0);
        @(negedge clk);
        reset     = 1'b0;
        bus.start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("abort_no_resume", int'(bus.done), 0);
        end
        run_search(8'd33, 1);

        // Random keys, biased half toward table hits.
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 1) key = 8'(2 * $urandom_range(0, 31) + 1);
            else key = 8'($urandom_range(0, 255));
            run_search(key, int'($urandom_range(0, 2)));
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
